// File: rtl/tt_cm_uart_tx_if.sv
// Handshake and serial-line bundle for the tt_cm UART transmitter.
interface tt_cm_uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/tt_cm_uart_tx.sv
// 8N1 byte-serial transmitter, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module tt_cm_uart_tx #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DATA_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    tt_cm_uart_tx_if.slave  tx_if
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd4,
`endif
        StStop   = 3'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_out_q, tx_out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign tick = (div_q == DivLast);

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_out_d = tx_out_q;
        ready_d  = 1'b0;
        busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                div_d = '0;
                bit_d = '0;
                if (tx_if.tx_valid && ready_q) begin
                    shift_d  = tx_if.tx_data;
                    state_d  = StStart;
                    tx_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.tx_data;
`endif
                end else begin
                    tx_out_d = 1'b1;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d  = StData;
                    tx_out_d = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = StParity;
                        tx_out_d = parity_q;
`else
                        state_d  = StStop;
                        tx_out_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        tx_out_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d  = StStop;
                    tx_out_d = 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    state_d  = StIdle;
                    tx_out_d = 1'b1;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = StIdle;
                div_d    = '0;
                bit_d    = '0;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_if.tx_out   = tx_out_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.busy     = busy_q;

endmodule

// File: tb/tb_tt_cm_uart_tx.sv
// Directed self-checking bench for tt_cm_uart_tx with CLK_DIV=4.
module tb_tt_cm_uart_tx;

    localparam int unsigned Div = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    tt_cm_uart_tx_if #(.DATA_W(8)) tx_if ();

    tt_cm_uart_tx #(
        .CLK_DIV (Div),
        .DATA_W  (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NBits == 11) return ^b;
        return 1'b1;
    endfunction

    // Leaves tx_valid high; returns just after the accept edge.
    task automatic send_start(input logic [7:0] b);
        int n = 0;
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        while (tx_if.tx_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("accept_wait", 32'(n < 100), 1);
        step();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        for (int i = 0; i < NBits * int'(Div); i++) begin
            check({tag, "_line"}, tx_if.tx_out, exp_bit(b, i / int'(Div)));
            check({tag, "_ready_low"}, tx_if.tx_ready, 0);
            check({tag, "_busy"}, tx_if.busy, 1);
            step();
        end
        check({tag, "_ready_back"}, tx_if.tx_ready, 1);
        check({tag, "_idle_line"}, tx_if.tx_out, 1);
        check({tag, "_idle_busy"}, tx_if.busy, 0);
    endtask

    initial begin
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        // Reset values held across three edges, with a valid pending to prove rst dominates.
        rst = 1'b1;
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx_out", tx_if.tx_out, 1);
            check("rst_ready", tx_if.tx_ready, 0);
            check("rst_busy", tx_if.busy, 0);
        end
        tx_if.tx_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_ready", tx_if.tx_ready, 1);
        check("post_rst_line", tx_if.tx_out, 1);

        // Basic frame.
        send_start(8'hA5);
        tx_if.tx_valid = 1'b0;
        check_frame("a5", 8'hA5);

        // Back-to-back with data switched on the accept edge.
        send_start(8'h00);
        tx_if.tx_data = 8'hFF;
        check_frame("b2b_00", 8'h00);
        step();
        tx_if.tx_valid = 1'b0;
        check_frame("b2b_ff", 8'hFF);

        // Data change mid-frame must not disturb the line.
        send_start(8'h81);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h3C;
        check_frame("stable_81", 8'h81);

        // Reset during data bit 3 of 0x55.
        send_start(8'h55);
        tx_if.tx_valid = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check("mid_pre_line", tx_if.tx_out, 0);
        rst = 1'b1;
        step();
        check("mid_rst_line", tx_if.tx_out, 1);
        check("mid_rst_busy", tx_if.busy, 0);
        check("mid_rst_ready", tx_if.tx_ready, 0);
        rst = 1'b0;
        step();
        check("mid_rel_ready", tx_if.tx_ready, 1);
        send_start(8'h0F);
        tx_if.tx_valid = 1'b0;
        check_frame("after_rst_0f", 8'h0F);

`ifdef UART_TX_PARITY_EN
        send_start(8'h07);
        tx_if.tx_valid = 1'b0;
        check_frame("par_07", 8'h07);
        send_start(8'h03);
        tx_if.tx_valid = 1'b0;
        check_frame("par_03", 8'h03);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
